hsid_mse_multi: RTL and testbench
=================================

# hsid_mse_multi

Parametrised mean-square-error engine for hyperspectral pixel-vs-library comparison. Processes `LANES = WORD_WIDTH/DATA_WIDTH` packed band samples per beat and accumulates each lane. At the end of each vector it reduces the lanes and emits one MSE (or raw SSE) per reference vector. It adds a valid/ready back-pressure path, runtime band-count configuration and an element-count error check. It sits between the pixel/library streaming front end and the minimum-distance selector.

## Interface
- `WORD_WIDTH`, 64: input word width; must be a multiple of `DATA_WIDTH`.
- `DATA_WIDTH`, 16: unsigned sample width per lane.
- `DATA_WIDTH_MUL`, 32: squared-difference width; at least `2*DATA_WIDTH`.
- `DATA_WIDTH_ACC`, 48: per-lane accumulator width; accumulators saturate.
- `HSI_BANDS_MAX`, 256: maximum bands per vector; sets the element counter width.
- `HSI_LIBRARY_SIZE`, 256: library depth; `REF_W = $clog2(HSI_LIBRARY_SIZE)`.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `cfg_mode  in  1`: 0 = MSE (shifted); 1 = SSE (raw sum).
- `cfg_shift  in  $clog2(HSI_BANDS_MAX)+1`: right shift applied in MSE mode (log2 of bands).
- `cfg_elements  in  $clog2(HSI_BANDS_MAX)+1`: expected beats per vector.
- `element_valid  in  1`: input beat valid.
- `element_ready  out  1`: input beat accepted when valid && ready.
- `element_start`, `element_last  in  1`: first and last beat of a vector.
- `vctr_ref  in  REF_W`: library index of the vector.
- `element_a`, `element_b  in  WORD_WIDTH`: packed samples; lane i = bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `mse_value  out  WORD_WIDTH`: result.
- `mse_ref  out  REF_W`: library index of the result.
- `mse_error  out  1`: beat-count mismatch for this result.
- `mse_valid  out  1`: result valid; held until `mse_ready`.
- `mse_ready  in  1`: downstream accepts the result.

## Operation
- Global advance `adv = !mse_valid || mse_ready`.
  - `element_ready = adv` (combinational).
  - All pipeline stages advance only when `adv`; a stall freezes every stage.
- Control FSM has two states, IDLE and ACCUM.
  - In IDLE, an accepted beat with `start` latches `cfg_*` and `vctr_ref`, sets count = 1, goes to ACCUM, or stays in IDLE if `last` is also set.
  - In IDLE, an accepted beat without `start` is dropped and has no effect.
  - In ACCUM, an accepted beat increments count. A beat with `last` closes the vector and returns to IDLE.
  - In ACCUM, a beat with `start` abandons the partial vector without producing a result and restarts as in IDLE.
- Configuration is sampled only on the start beat; changes mid-vector are ignored.
- S1, per lane: `d = |a_i - b_i|`, register `d*d`, zero-extended to `DATA_WIDTH_MUL`.
- S2, per lane: the start beat loads the accumulator with `d*d`; later beats add to it. Saturate at `2^DATA_WIDTH_ACC - 1`.
- S3: sum of all lane accumulators, width `DATA_WIDTH_ACC + $clog2(LANES)`, registered on the closing beat only.
- S4, output register:
  - MSE mode: `sum >> shift`, saturated to `2^WORD_WIDTH - 1`.
  - SSE mode: `sum`, saturated to the same value.
  - `mse_error = (count != cfg_elements)`.
- Dropped and abandoned beats never produce `mse_valid`.

## Timing
- Latency: closing beat accepted in cycle t gives `mse_valid` high in cycle t+4, with no stall.
- Throughput: one beat per cycle. Back-to-back vectors are allowed, including a `start` beat in the cycle after a `last` beat.
- When `mse_valid && !mse_ready`:
  - `element_ready` is low.
  - `mse_value`, `mse_ref` and `mse_error` are held stable.
- Result handoff: in the cycle `mse_valid && mse_ready`, a following result may load in the same edge.
- Reset values, at any time including mid-vector:
  - `mse_value`, `mse_ref`, `mse_error`, `mse_valid` = 0.
  - All accumulators = 0, FSM = IDLE, in-flight vectors discarded.
  - `element_ready` = 1 once reset is asserted.
- A single-beat vector (start && last) is legal: count = 1.

## Structure
- `hsid_mse_pkg` holds:
  - the mode enum (`MSE`, `SSE`) and the FSM state enum;
  - the `LANES` and accumulator/sum width functions;
  - the saturating add/resize helpers.
- Sub-module `hsid_mse_lane`, instantiated `LANES` times via generate: S1 square-difference plus S2 saturating accumulator with `adv` enable.
- The top holds the FSM, counter, reduction tree, shift/saturate stage and output handshake.

## Test plan
- Default params, `cfg_elements=32`, `shift=7`, MSE mode; all lanes a=3, b=1 for 32 beats, ref=5 -> `mse_value=4`, `mse_ref=5`, `mse_error=0`, valid 4 cycles after the last beat.
- Same stimulus in SSE mode -> `mse_value=512`. Lanes a=0xFFFF, b=0, 256 beats -> value equals the unsaturated sum, with no accumulator wrap.
- `cfg_elements=32` but `last` on beat 30 -> result emitted with `mse_error=1`; `start` on beat 10 of an open vector -> no result for the abandoned vector.
- Hold `mse_ready=0` for 10 cycles while results pend -> `element_ready=0` and outputs stable. Release -> results appear in order with no loss or duplication.
- Back-to-back single-beat vectors, ref 0..7, a lane0=2, b=0, SSE mode -> eight results, values 4 and refs 0..7 in order, one per cycle.
- Assert `rst` mid-vector, then send a fresh vector -> all outputs 0 during reset, only the fresh vector's result appears, and it is correct.

Source files
------------

// File: rtl/hsid_mse_pkg.sv
// Shared types and helpers for the hyperspectral MSE engine: mode/state enums,
// derived-width functions and saturating arithmetic on a wide scratch type.
package hsid_mse_pkg;

  typedef enum logic {MSE = 1'b0, SSE = 1'b1} mode_t;
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Scratch width for helpers; every engine width must stay below this.
  localparam int WIDE_W = 128;
  typedef logic [WIDE_W-1:0] wide_t;

  function automatic int lanes_f(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  function automatic int sum_w_f(input int acc_w, input int lanes);
    return acc_w + $clog2(lanes);
  endfunction

  function automatic wide_t max_of(input int w);
    return (w >= WIDE_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    wide_t s;
    s = a + b;
    return (s > max_of(w) || s < a) ? max_of(w) : s;
  endfunction

  function automatic wide_t sat_resize(input wide_t v, input int w);
    return (v > max_of(w)) ? max_of(w) : v;
  endfunction

endpackage

// File: rtl/hsid_mse_lane.sv
// One lane: registered squared difference, then a saturating accumulator.
// Two-cycle path from sample to accumulator; both stages freeze when adv is low.
module hsid_mse_lane
  import hsid_mse_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_MUL = 32,
  parameter int DATA_WIDTH_ACC = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic                      s1_vld,
  input  logic                      s1_load,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH_ACC-1:0] acc
);

  logic [DATA_WIDTH-1:0]     d;
  logic [DATA_WIDTH_MUL-1:0] sq;

  assign d = (a > b) ? (a - b) : (b - a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq  <= '0;
      acc <= '0;
    end else if (adv) begin
      sq <= DATA_WIDTH_MUL'(d) * DATA_WIDTH_MUL'(d);
      // s1 flags describe the beat whose square is currently in sq
      if (s1_vld)
        acc <= s1_load ? DATA_WIDTH_ACC'(sq)
                       : DATA_WIDTH_ACC'(sat_add(wide_t'(acc), wide_t'(sq), DATA_WIDTH_ACC));
    end
  end

endmodule

// File: rtl/hsid_mse_multi.sv
// Multi-lane MSE/SSE engine: per-vector lane accumulate, reduce, shift, saturate.
// Closing beat to mse_valid is 4 cycles; a held result stalls the whole pipeline.
module hsid_mse_multi
  import hsid_mse_pkg::*;
#(
  parameter int WORD_WIDTH       = 64,
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_WIDTH_MUL   = 32,
  parameter int DATA_WIDTH_ACC   = 48,
  parameter int HSI_BANDS_MAX    = 256,
  parameter int HSI_LIBRARY_SIZE = 256,
  localparam int REF_W = $clog2(HSI_LIBRARY_SIZE),
  localparam int CFG_W = $clog2(HSI_BANDS_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_mode,
  input  logic [CFG_W-1:0]      cfg_shift,
  input  logic [CFG_W-1:0]      cfg_elements,
  input  logic                  element_valid,
  output logic                  element_ready,
  input  logic                  element_start,
  input  logic                  element_last,
  input  logic [REF_W-1:0]      vctr_ref,
  input  logic [WORD_WIDTH-1:0] element_a,
  input  logic [WORD_WIDTH-1:0] element_b,
  output logic [WORD_WIDTH-1:0] mse_value,
  output logic [REF_W-1:0]      mse_ref,
  output logic                  mse_error,
  output logic                  mse_valid,
  input  logic                  mse_ready
);

  localparam int LANES = lanes_f(WORD_WIDTH, DATA_WIDTH);
  localparam int SUM_W = sum_w_f(DATA_WIDTH_ACC, LANES);

  typedef struct packed {
    logic [REF_W-1:0] ref_idx;
    mode_t            mode;
    logic [CFG_W-1:0] shift;
    logic             err;
  } meta_t;

  logic                      adv, use_beat, load_beat, close_beat;
  state_t                    state, state_nxt;
  logic [CFG_W-1:0]          count, cnt_eff, shift_q, elems_q;
  logic [REF_W-1:0]          ref_q;
  mode_t                     mode_q;
  meta_t                     meta_eff, s1_meta, s2_meta, s3_meta;
  logic                      s1_vld, s1_load, s1_close, s2_close, s3_vld;
  logic [SUM_W-1:0]          lane_sum, s3_sum;
  logic [DATA_WIDTH_ACC-1:0] lane_acc [LANES];
  wide_t                     res;

  assign adv           = !mse_valid || mse_ready;
  assign element_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    use_beat   = 1'b0;
    load_beat  = 1'b0;
    close_beat = 1'b0;
    if (element_valid && adv) begin
      case (state)
        IDLE: begin
          use_beat  = element_start;
          load_beat = element_start;
        end
        ACCUM: begin
          use_beat  = 1'b1;
          load_beat = element_start;
        end
        default: ;
      endcase
      close_beat = use_beat && element_last;
      if (use_beat) state_nxt = element_last ? IDLE : ACCUM;
    end
  end

  // Start-beat values are used directly so single-beat vectors see their own cfg.
  always_comb begin
    cnt_eff          = load_beat ? CFG_W'(1) : ((&count) ? count : count + CFG_W'(1));
    meta_eff.ref_idx = load_beat ? vctr_ref : ref_q;
    meta_eff.mode    = load_beat ? mode_t'(cfg_mode) : mode_q;
    meta_eff.shift   = load_beat ? cfg_shift : shift_q;
    meta_eff.err     = cnt_eff != (load_beat ? cfg_elements : elems_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      ref_q   <= '0;
      mode_q  <= MSE;
      shift_q <= '0;
      elems_q <= '0;
    end else begin
      if (use_beat) count <= cnt_eff;
      if (load_beat) begin
        ref_q   <= vctr_ref;
        mode_q  <= mode_t'(cfg_mode);
        shift_q <= cfg_shift;
        elems_q <= cfg_elements;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    hsid_mse_lane #(
      .DATA_WIDTH     (DATA_WIDTH),
      .DATA_WIDTH_MUL (DATA_WIDTH_MUL),
      .DATA_WIDTH_ACC (DATA_WIDTH_ACC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .s1_vld  (s1_vld),
      .s1_load (s1_load),
      .a       (element_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b       (element_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .acc     (lane_acc[i])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SUM_W'(lane_acc[i]);
  end

  always_comb begin
    res = wide_t'(s3_sum);
    if (s3_meta.mode == MSE) res = res >> s3_meta.shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_load   <= 1'b0;
      s1_close  <= 1'b0;
      s1_meta   <= '0;
      s2_close  <= 1'b0;
      s2_meta   <= '0;
      s3_vld    <= 1'b0;
      s3_sum    <= '0;
      s3_meta   <= '0;
      mse_valid <= 1'b0;
      mse_value <= '0;
      mse_ref   <= '0;
      mse_error <= 1'b0;
    end else if (adv) begin
      s1_vld    <= use_beat;
      s1_load   <= load_beat;
      s1_close  <= close_beat;
      s1_meta   <= meta_eff;
      s2_close  <= s1_close;
      s2_meta   <= s1_meta;
      // lane accumulators now hold the closing beat's contribution
      s3_vld    <= s2_close;
      if (s2_close) begin
        s3_sum  <= lane_sum;
        s3_meta <= s2_meta;
      end
      mse_valid <= s3_vld;
      if (s3_vld) begin
        mse_value <= WORD_WIDTH'(sat_resize(res, WORD_WIDTH));
        mse_ref   <= s3_meta.ref_idx;
        mse_error <= s3_meta.err;
      end
    end
  end

endmodule

// File: tb/tb_hsid_mse_multi.sv
// Directed + randomized bench for hsid_mse_multi against a vector-level reference model.
module tb_hsid_mse_multi;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam logic [127:0] ACC_MAX  = (128'd1 << 48) - 128'd1;
  localparam logic [127:0] WORD_MAX = (128'd1 << 64) - 128'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mode;
  logic [8:0]  cfg_shift, cfg_elements;
  logic        element_valid, element_ready, element_start, element_last;
  logic [7:0]  vctr_ref;
  logic [63:0] element_a, element_b;
  logic [63:0] mse_value;
  logic [7:0]  mse_ref;
  logic        mse_error, mse_valid, mse_ready;

  hsid_mse_multi dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_shift     (cfg_shift),
    .cfg_elements  (cfg_elements),
    .element_valid (element_valid),
    .element_ready (element_ready),
    .element_start (element_start),
    .element_last  (element_last),
    .vctr_ref      (vctr_ref),
    .element_a     (element_a),
    .element_b     (element_b),
    .mse_value     (mse_value),
    .mse_ref       (mse_ref),
    .mse_error     (mse_error),
    .mse_valid     (mse_valid),
    .mse_ready     (mse_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int n_results = 0;
  bit chk_lat = 1'b1;
  bit rnd_rdy = 1'b0;
  logic [63:0] last_val;
  logic [7:0]  last_ref;
  logic        last_err;

  typedef struct {
    logic [63:0] val;
    logic [7:0]  rf;
    logic        err;
    int          due;
  } exp_t;
  exp_t expq[$];

  // Reference model: one open vector with per-lane running sums.
  bit           m_open = 1'b0;
  int           m_cnt, m_shift, m_elem;
  logic         m_mode;
  logic [7:0]   m_ref;
  logic [127:0] m_lane [LANES];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat();
    logic [127:0] av, bv, d, tot, val;
    exp_t e;
    if (element_start) begin
      m_open  = 1'b1;
      m_cnt   = 0;
      m_mode  = cfg_mode;
      m_shift = int'(cfg_shift);
      m_elem  = int'(cfg_elements);
      m_ref   = vctr_ref;
      for (int i = 0; i < LANES; i++) m_lane[i] = '0;
    end else if (!m_open) begin
      return;
    end
    m_cnt++;
    for (int i = 0; i < LANES; i++) begin
      av = 128'(element_a[i*DW +: DW]);
      bv = 128'(element_b[i*DW +: DW]);
      d  = (av > bv) ? av - bv : bv - av;
      m_lane[i] = m_lane[i] + d * d;
      if (m_lane[i] > ACC_MAX) m_lane[i] = ACC_MAX;
    end
    if (element_last) begin
      tot = '0;
      for (int i = 0; i < LANES; i++) tot = tot + m_lane[i];
      val = m_mode ? tot : (tot >> m_shift);
      if (val > WORD_MAX) val = WORD_MAX;
      e.val = val[63:0];
      e.rf  = m_ref;
      e.err = (m_cnt != m_elem);
      e.due = cyc + 4;
      expq.push_back(e);
      m_open = 1'b0;
    end
  endtask

  // Monitor: scoreboard, hold-stability while stalled, and model update.
  initial begin
    exp_t        e;
    bit          stalled = 1'b0;
    logic [63:0] h_val;
    logic [7:0]  h_ref;
    logic        h_err;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_open  = 1'b0;
        expq.delete();
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_value", mse_value, h_val);
          chk("hold_ref", 64'(mse_ref), 64'(h_ref));
          chk("hold_err", 64'(mse_error), 64'(h_err));
          chk("hold_valid", 64'(mse_valid), 64'd1);
        end
        if (mse_valid && mse_ready) begin
          chk("result_expected", 64'(expq.size() > 0), 64'd1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("res_value", mse_value, e.val);
            chk("res_ref", 64'(mse_ref), 64'(e.rf));
            chk("res_err", 64'(mse_error), 64'(e.err));
            if (chk_lat) chk("res_latency", 64'(cyc), 64'(e.due));
          end
          last_val = mse_value;
          last_ref = mse_ref;
          last_err = mse_error;
          n_results++;
        end
        if (element_valid && element_ready) model_beat();
        stalled = mse_valid && !mse_ready;
        h_val = mse_value;
        h_ref = mse_ref;
        h_err = mse_error;
      end
    end
  end

  // Random downstream back-pressure, active only when rnd_rdy is set.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) mse_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic beat(input logic [63:0] a, input logic [63:0] b,
                      input logic s, input logic l, input logic [7:0] r);
    bit ok = 1'b0;
    element_valid = 1'b1;
    element_a     = a;
    element_b     = b;
    element_start = s;
    element_last  = l;
    vctr_ref      = r;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = element_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    element_valid = 1'b0;
    element_start = 1'b0;
    element_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (expq.size() == 0 && !mse_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(expq.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_reset_outputs();
    chk("rst_valid", 64'(mse_valid), 64'd0);
    chk("rst_value", mse_value, 64'd0);
    chk("rst_ref", 64'(mse_ref), 64'd0);
    chk("rst_err", 64'(mse_error), 64'd0);
    chk("rst_ready", 64'(element_ready), 64'd1);
  endtask

  initial begin
    int n0, len;
    rst = 1'b1;
    cfg_mode = 1'b0; cfg_shift = 9'd7; cfg_elements = 9'd32;
    element_valid = 1'b0; element_start = 1'b0; element_last = 1'b0;
    vctr_ref = '0; element_a = '0; element_b = '0;
    mse_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // MSE: 4 lanes * 32 beats * 4 = 512, >> 7 = 4
    for (int i = 0; i < 32; i++)
      beat(64'h0003_0003_0003_0003, 64'h0001_0001_0001_0001, i == 0, i == 31, 8'd5);
    idle(0);
    drain();
    chk("t1_value", last_val, 64'd4);
    chk("t1_ref", 64'(last_ref), 64'd5);
    chk("t1_err", 64'(last_err), 64'd0);

    cfg_mode = 1'b1;
    for (int i = 0; i < 32; i++)
      beat(64'h0003_0003_0003_0003, 64'h0001_0001_0001_0001, i == 0, i == 31, 8'd5);
    idle(0);
    drain();
    chk("t2_sse_value", last_val, 64'd512);

    // Full-scale samples over 256 bands: must not wrap any accumulator
    cfg_elements = 9'd256;
    for (int i = 0; i < 256; i++)
      beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, i == 0, i == 255, 8'd200);
    idle(0);
    drain();
    chk("t2_full_value", last_val, 64'd4397912294400);
    chk("t2_full_err", 64'(last_err), 64'd0);

    // Short vector: last on beat 30 of an expected 32
    cfg_mode = 1'b0; cfg_shift = 9'd5; cfg_elements = 9'd32;
    for (int i = 0; i < 30; i++) beat(rnd64(), rnd64(), i == 0, i == 29, 8'd17);
    idle(0);
    drain();
    chk("t3_err", 64'(last_err), 64'd1);

    // Stray beats in IDLE, then a vector abandoned by a restart on beat 10
    n0 = n_results;
    for (int i = 0; i < 3; i++) beat(rnd64(), rnd64(), 1'b0, i == 1, 8'd99);
    for (int i = 0; i < 9; i++) beat(rnd64(), rnd64(), i == 0, 1'b0, 8'd40);
    cfg_shift = 9'd2;
    for (int i = 0; i < 32; i++) beat(rnd64(), rnd64(), i == 0, i == 31, 8'd41);
    idle(0);
    drain();
    chk("t4_count", 64'(n_results - n0), 64'd1);
    chk("t4_ref", 64'(last_ref), 64'd41);
    chk("t4_err", 64'(last_err), 64'd0);

    // Downstream stall with three results in flight
    n0 = n_results;
    chk_lat = 1'b0;
    mse_ready = 1'b0;
    cfg_mode = 1'b1; cfg_elements = 9'd1;
    beat(rnd64(), rnd64(), 1'b1, 1'b1, 8'd10);
    beat(rnd64(), rnd64(), 1'b1, 1'b1, 8'd11);
    beat(rnd64(), rnd64(), 1'b1, 1'b1, 8'd12);
    idle(0);
    for (int k = 0; k < 20; k++) begin
      if (mse_valid) break;
      @(posedge clk);
      #1;
    end
    repeat (10) begin
      @(negedge clk);
      chk("stall_ready", 64'(element_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    mse_ready = 1'b1;
    drain();
    chk("t5_count", 64'(n_results - n0), 64'd3);
    chk("t5_last_ref", 64'(last_ref), 64'd12);

    // Randomized vectors under random back-pressure
    rnd_rdy = 1'b1;
    for (int v = 0; v < 24; v++) begin
      len = $urandom_range(1, 8);
      cfg_mode     = 1'($urandom_range(0, 1));
      cfg_shift    = 9'($urandom_range(0, 4));
      cfg_elements = 9'($urandom_range(1, 8));
      for (int i = 0; i < len; i++)
        beat(rnd64(), rnd64(), i == 0, i == len - 1, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(0);
    rnd_rdy = 1'b0;
    mse_ready = 1'b1;
    drain();
    chk_lat = 1'b1;

    // Back-to-back single-beat vectors, one result per cycle
    n0 = n_results;
    cfg_mode = 1'b1;
    for (int r = 0; r < 8; r++) beat(64'h2, 64'h0, 1'b1, 1'b1, 8'(r));
    idle(0);
    drain();
    chk("t6_count", 64'(n_results - n0), 64'd8);
    chk("t6_last_ref", 64'(last_ref), 64'd7);
    chk("t6_last_val", last_val, 64'd4);

    // Reset with a result in flight and a vector open
    cfg_mode = 1'b0; cfg_shift = 9'd0; cfg_elements = 9'd5;
    for (int i = 0; i < 5; i++) beat(rnd64(), rnd64(), i == 0, i == 4, 8'd60);
    for (int i = 0; i < 2; i++) beat(rnd64(), rnd64(), i == 0, 1'b0, 8'd61);
    idle(0);
    n0 = n_results;
    rst = 1'b1;
    mse_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mse_ready = 1'b1;
    cfg_mode = 1'b1; cfg_elements = 9'd4;
    for (int i = 0; i < 4; i++)
      beat(64'h0005_0005_0005_0005, 64'h0002_0002_0002_0002, i == 0, i == 3, 8'd9);
    idle(0);
    drain();
    chk("t7_count", 64'(n_results - n0), 64'd1);
    chk("t7_value", last_val, 64'd144);
    chk("t7_ref", 64'(last_ref), 64'd9);
    chk("t7_err", 64'(last_err), 64'd0);

    idle(6);
    chk("final_queue", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
